// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with stall detect; PWM_CAPTURE_DUTY_DIV_EN adds a duty-in-tenths divider
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic [3:0]       duty_tenths,
  output logic             duty_valid
);

  typedef enum logic [1:0] {ARM, MEAS, STALL} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic             s1_q, pwm_s_q, pwm_d_q;
  logic             rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_acc_q, per_acc_d;
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_hi_q, stuck_hi_d;
  logic             stuck_lo_q, stuck_lo_d;

  assign rise = pwm_s_q & ~pwm_d_q;

  // Two-flop synchroniser on the raw pin plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      s1_q    <= pwm_in;
      pwm_s_q <= s1_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  // Next-state, accumulators and result capture; a rise beats the timeout compare
  always_comb begin
    state_d      = state_q;
    per_acc_d    = per_acc_q;
    hi_acc_d     = hi_acc_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    if (!ena) begin
      state_d   = ARM;
      per_acc_d = '0;
      hi_acc_d  = '0;
    end else begin
      case (state_q)
        ARM: begin
          if (rise) begin
            state_d   = MEAS;
            per_acc_d = CNT_W'(1);
            hi_acc_d  = CNT_W'(1);
          end
        end
        MEAS: begin
          if (rise) begin
            period_d     = per_acc_q;
            high_d       = hi_acc_q;
            meas_valid_d = 1'b1;
            per_acc_d    = CNT_W'(1);
            hi_acc_d     = CNT_W'(1);
          end else if (per_acc_q == TO_VAL) begin
            state_d   = STALL;
            period_d  = '0;
            high_d    = '0;
            per_acc_d = '0;
            hi_acc_d  = '0;
          end else begin
            per_acc_d = per_acc_q + CNT_W'(1);
            hi_acc_d  = hi_acc_q + CNT_W'(pwm_s_q);
          end
        end
        STALL: begin
          if (rise) begin
            state_d   = MEAS;
            per_acc_d = CNT_W'(1);
            hi_acc_d  = CNT_W'(1);
          end
        end
        default: state_d = ARM;
      endcase
    end
    stuck_hi_d = (state_d == STALL) &  pwm_s_q;
    stuck_lo_d = (state_d == STALL) & ~pwm_s_q;
  end

  // Measurement state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARM;
      per_acc_q    <= '0;
      hi_acc_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_acc_q    <= per_acc_d;
      hi_acc_q     <= hi_acc_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
    end
  end

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign meas_valid = meas_valid_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;

`ifdef PWM_CAPTURE_DUTY_DIV_EN
  localparam int DIV_N = CNT_W + 4;
  localparam int DCW   = $clog2(DIV_N + 1);

  logic             div_start, div_abort, div_ge;
  logic [DIV_N-1:0] div_num;
  logic [CNT_W:0]   rem_shift;
  logic             busy_q, busy_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_N-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [3:0]       duty_q, duty_d;
  logic             duty_valid_q, duty_valid_d;

  // Divider is loaded from the same values being captured, so it starts with meas_valid
  assign div_start = meas_valid_d;
  assign div_abort = !ena || ((state_q != STALL) && (state_d == STALL));
  assign div_num   = ({4'b0, hi_acc_q} << 3) + ({4'b0, hi_acc_q} << 1);
  assign rem_shift = {rem_q, quo_q[DIV_N-1]};
  assign div_ge    = rem_shift >= {1'b0, den_q};

  // Restoring division, one quotient bit per cycle; a new start discards any run in flight
  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    den_d        = den_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    if (div_abort) begin
      busy_d = 1'b0;
      duty_d = '0;
    end else if (div_start) begin
      busy_d = 1'b1;
      cnt_d  = DCW'(DIV_N);
      rem_d  = '0;
      quo_d  = div_num;
      den_d  = per_acc_q;
    end else if (busy_q) begin
      rem_d = div_ge ? CNT_W'(rem_shift - {1'b0, den_q}) : rem_shift[CNT_W-1:0];
      quo_d = {quo_q[DIV_N-2:0], div_ge};
      cnt_d = cnt_q - DCW'(1);
      if (cnt_q == DCW'(1)) begin
        busy_d       = 1'b0;
        duty_d       = quo_d[3:0];
        duty_valid_d = 1'b1;
      end
    end
  end

  // Divider registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      den_q        <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      den_q        <= den_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign duty_tenths = duty_q;
  assign duty_valid  = duty_valid_q;
`else
  assign duty_tenths = 4'd0;
  assign duty_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed and random PWM stimulus against a rise-to-rise reference model
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int DIV_LAT = CNT_W + 4;

  logic             clk = 1'b0;
  logic             rst_n, ena, pwm_in;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_valid, stuck_hi, stuck_lo, duty_valid;
  logic [3:0]       duty_tenths;

  typedef struct {int p; int h;} meas_t;
  meas_t exp_q[$];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   t_now = 0, last_rise = 0, hi_since = 0, n_pushed = 0, n_seen = 0;
  bit   armed = 1'b0;
  logic last_v = 1'b0;
  int   since = -1, dp = 1, dh = 0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo),
    .duty_tenths(duty_tenths), .duty_valid(duty_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One input cycle; the model measures rise-to-rise on the driven waveform
  task automatic cyc(input logic v);
    pwm_in = v;
    if (v && !last_v) begin
      if (!ena) armed = 1'b0;
      else begin
        if (armed && (t_now - last_rise) <= TIMEOUT) begin
          exp_q.push_back('{t_now - last_rise, hi_since});
          n_pushed++;
        end
        armed = 1'b1; last_rise = t_now; hi_since = 0;
      end
    end
    if (v) hi_since++;
    last_v = v;
    t_now++;
    @(posedge clk); #1;
  endtask

  task automatic period(input int h, input int l);
    repeat (h) cyc(1'b1);
    repeat (l) cyc(1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_stuck_hi"}, stuck_hi, 0);
    chk({tag, "_stuck_lo"}, stuck_lo, 0);
    chk({tag, "_duty"}, duty_tenths, 0);
    chk({tag, "_duty_valid"}, duty_valid, 0);
  endtask

  // Scoreboard: every meas_valid must match the next modelled period, duty follows DIV_LAT later
  always @(negedge clk) begin
    if (meas_valid) begin
      n_seen++;
      chk("meas_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        meas_t e;
        e = exp_q.pop_front();
        chk("meas_period", period_cnt, e.p);
        chk("meas_high", high_cnt, e.h);
      end
      chk("inv_high_le_period", high_cnt <= period_cnt, 1);
`ifndef PWM_CAPTURE_DUTY_DIV_EN
      chk("no_div_duty", duty_tenths, 0);
      chk("no_div_duty_valid", duty_valid, 0);
`endif
    end
`ifdef PWM_CAPTURE_DUTY_DIV_EN
    if (since >= 0) since++;
    if (!rst_n || !ena || stuck_hi || stuck_lo) since = -1;
    if (duty_valid) begin
      chk("duty_latency", since, DIV_LAT);
      chk("duty_value", duty_tenths, (dh * 10) / dp);
    end
    if (meas_valid) begin
      since = 0; dp = int'(period_cnt); dh = int'(high_cnt);
    end
`endif
  end

  // Directed sequence with a random section
  initial begin
    pwm_in = 1'b0; ena = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // 5 high / 5 low: first rise arms, exact latency on the second rise
    period(5, 5);
    cyc(1'b1); chk("lat_k", meas_valid, 0);
    cyc(1'b1); chk("lat_k1", meas_valid, 0);
    cyc(1'b1); chk("lat_k2_valid", meas_valid, 1);
    chk("lat_k2_period", period_cnt, 10);
    chk("lat_k2_high", high_cnt, 5);
    cyc(1'b1); chk("pulse_one_cycle", meas_valid, 0);
    cyc(1'b1);
    repeat (5) cyc(1'b0);
    repeat (3) period(5, 5);

    // Extreme duty cycles
    repeat (4) period(9, 1);
    repeat (4) period(1, 9);
    repeat (2) period(5, 5);

    // Stall high, then low, then recover
    repeat (1100) cyc(1'b1);
    chk("stall_hi", stuck_hi, 1);
    chk("stall_hi_lo", stuck_lo, 0);
    chk("stall_period", period_cnt, 0);
    chk("stall_high", high_cnt, 0);
    chk("stall_duty", duty_tenths, 0);
    repeat (10) cyc(1'b0);
    chk("stall_lo", stuck_lo, 1);
    chk("stall_lo_hi", stuck_hi, 0);
    repeat (4) cyc(1'b1);
    chk("recover_hi_clear", stuck_hi, 0);
    chk("recover_lo_clear", stuck_lo, 0);
    cyc(1'b1);
    repeat (5) cyc(1'b0);
    repeat (3) period(5, 5);

    // One-cycle reset mid-period
    repeat (5) cyc(1'b1);
    repeat (4) cyc(1'b0);
    rst_n = 1'b0; armed = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    chk_zero_outputs("midreset");
    repeat (3) cyc(1'b0);
    repeat (3) period(5, 5);

    // ena low for 30 cycles during 20-cycle / 7-high PWM
    repeat (3) period(7, 13);
    repeat (7) cyc(1'b1);
    repeat (5) cyc(1'b0);
    ena = 1'b0; armed = 1'b0;
    repeat (8) cyc(1'b0);
    period(7, 13);
    repeat (2) cyc(1'b0);
    chk("ena_hold_period", period_cnt, 20);
    chk("ena_hold_high", high_cnt, 7);
    chk("ena_stuck_hi", stuck_hi, 0);
    chk("ena_stuck_lo", stuck_lo, 0);
    ena = 1'b1;
    repeat (11) cyc(1'b0);
    repeat (3) period(7, 13);

    // Random periods
    repeat (40) period($urandom_range(1, 12), $urandom_range(1, 12));

    // Short 4-cycle PWM keeps restarting the divider; the last result must survive
    repeat (6) period(3, 1);
    repeat (30) cyc(1'b0);
`ifdef PWM_CAPTURE_DUTY_DIV_EN
    chk("final_duty", duty_tenths, 7);
`else
    chk("final_duty", duty_tenths, 0);
`endif
    chk("final_period", period_cnt, 4);
    chk("final_high", high_cnt, 3);

    repeat (5) cyc(1'b0);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("meas_count", n_seen, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
